// File: rtl/uart_tx_frame.sv
// UART serialiser with a valid/ready payload handshake, runtime baud/parity/stop selection
// and a registered serial line. All frame settings are captured together on accept.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 100000000,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           baud_set,
  input  logic [1:0]           parity_sel,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BPS_9600   = 16'(CLK_FREQ / 9600);
  localparam logic [15:0] BPS_19200  = 16'(CLK_FREQ / 19200);
  localparam logic [15:0] BPS_38400  = 16'(CLK_FREQ / 38400);
  localparam logic [15:0] BPS_57600  = 16'(CLK_FREQ / 57600);
  localparam logic [15:0] BPS_115200 = 16'(CLK_FREQ / 115200);
  localparam logic [15:0] BPS_230400 = 16'(CLK_FREQ / 230400);
  localparam logic [15:0] BPS_460800 = 16'(CLK_FREQ / 460800);
  localparam logic [15:0] BPS_921600 = 16'(CLK_FREQ / 921600);
  localparam logic [3:0]  LAST_DATA  = 4'(DATA_BITS - 1);

  function automatic logic [15:0] bps_for(input logic [2:0] sel);
    case (sel)
      3'd0:    bps_for = BPS_9600;
      3'd1:    bps_for = BPS_19200;
      3'd2:    bps_for = BPS_38400;
      3'd3:    bps_for = BPS_57600;
      3'd4:    bps_for = BPS_115200;
      3'd5:    bps_for = BPS_230400;
      3'd6:    bps_for = BPS_460800;
      default: bps_for = BPS_921600;
    endcase
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] sel);
    case (sel)
      2'd1:    parity_bit = ~^d;
      2'd2:    parity_bit = ^d;
      2'd3:    parity_bit = 1'b1;
      default: parity_bit = 1'b0;
    endcase
  endfunction

  state_t                 state_r;
  logic [15:0]            bps_r;
  logic [15:0]            div_cnt_r;
  logic [3:0]             bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_en_r;
  logic                   par_bit_r;
  logic                   two_stop_r;
  logic                   tx_r;
  logic                   tx_done_r;
  logic                   bit_end_s;

  assign bit_end_s = (div_cnt_r == (bps_r - 16'd1));
  assign tx_ready  = (state_r == IDLE);
  assign busy      = ~tx_ready;
  assign tx        = tx_r;
  assign tx_done   = tx_done_r;

  // Frame sequencer: owns the state, bit timing, the serial line and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bps_r      <= 16'd0;
      div_cnt_r  <= 16'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      two_stop_r <= 1'b0;
      tx_r       <= 1'b1;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r      <= 1'b1;
          div_cnt_r <= 16'd0;
          bit_cnt_r <= 4'd0;
          if (tx_valid) begin
            // Everything the frame depends on is frozen here.
            bps_r      <= bps_for(baud_set);
            shift_r    <= tx_data;
            par_en_r   <= (parity_sel != 2'd0);
            par_bit_r  <= parity_bit(tx_data, parity_sel);
            two_stop_r <= two_stop;
            tx_r       <= 1'b0;
            state_r    <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            div_cnt_r <= 16'd0;
            bit_cnt_r <= 4'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            div_cnt_r <= 16'd0;
            if (bit_cnt_r == LAST_DATA) begin
              bit_cnt_r <= 4'd0;
              if (par_en_r) begin
                tx_r    <= par_bit_r;
                state_r <= PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= STOP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            end
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            div_cnt_r <= 16'd0;
            bit_cnt_r <= 4'd0;
            tx_r      <= 1'b1;
            state_r   <= STOP;
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        STOP: begin
          tx_r <= 1'b1;
          if (bit_end_s) begin
            div_cnt_r <= 16'd0;
            if (bit_cnt_r == (two_stop_r ? 4'd1 : 4'd0)) begin
              bit_cnt_r <= 4'd0;
              tx_done_r <= 1'b1;
              state_r   <= IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_r      <= 1'b1;
          div_cnt_r <= 16'd0;
          bit_cnt_r <= 4'd0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomised checks of uart_tx_frame against a bit-list reference model.
module tb_uart_tx_frame;

  localparam int CLK_FREQ  = 1152000;
  localparam int CLK5_FREQ = 9216000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] baud_set = 3'd4;
  logic [1:0] parity_sel = 2'd0;
  logic       two_stop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, tx_done;

  logic [2:0] b5_baud = 3'd7;
  logic [1:0] b5_par = 2'd3;
  logic       b5_ts = 1'b0;
  logic [4:0] b5_data = 5'h00;
  logic       b5_valid = 1'b0;
  logic       b5_ready, b5_tx, b5_busy, b5_done;

  int checks = 0;
  int failures = 0;
  int baud_tab [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .baud_set(baud_set), .parity_sel(parity_sel),
    .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_frame #(.CLK_FREQ(CLK5_FREQ), .DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .baud_set(b5_baud), .parity_sel(b5_par),
    .two_stop(b5_ts), .tx_data(b5_data), .tx_valid(b5_valid),
    .tx_ready(b5_ready), .tx(b5_tx), .busy(b5_busy), .tx_done(b5_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the tx_done cycle.
  task automatic frame(input logic [7:0] d, input logic [2:0] bs, input logic [1:0] par,
                       input logic ts, input bit b2b);
    bit q[$];
    int bps;
    int len;
    logic p;
    bps = CLK_FREQ / baud_tab[bs];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par != 2'd0) begin
      p = (par == 2'd3) ? 1'b1 : ((par == 2'd2) ? ^d : ~^d);
      q.push_back(p);
    end
    q.push_back(1'b1);
    if (ts) q.push_back(1'b1);
    len = q.size() * bps;
    tx_data = d; baud_set = bs; parity_sel = par; two_stop = ts; tx_valid = 1'b1;
    chk("ready_before_accept", tx_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!b2b) tx_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk("tx_wave", tx, q[k / bps]);
      chk("done_in_frame", tx_done, 1'b0);
      if (k == 0 || k == len - 1) begin
        chk("ready_in_frame", tx_ready, 1'b0);
        chk("busy_in_frame", busy, 1'b1);
      end
      if (!b2b && k == len / 2) begin
        tx_data = 8'($urandom); parity_sel = 2'($urandom);
        two_stop = 1'($urandom); baud_set = 3'($urandom);
      end
      @(negedge clk);
    end
    chk("done_pulse", tx_done, 1'b1);
    chk("tx_idle_at_done", tx, 1'b1);
    chk("ready_at_done", tx_ready, 1'b1);
    chk("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    int bps5;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_tx", tx, 1'b1);
    chk("idle_done", tx_done, 1'b0);

    // T1: 8N1 0x55, 100-cycle frame
    frame(8'h55, 3'd4, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", tx_done, 1'b0);

    // T2: even and odd parity on 0x07
    frame(8'h07, 3'd4, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    frame(8'h07, 3'd4, 2'd1, 1'b0, 1'b0);
    @(negedge clk);

    // T3: 8N2, inputs scrambled mid-frame inside frame()
    frame(8'hA3, 3'd4, 2'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_spurious_done", tx_done, 1'b0);

    // T4: back-to-back with tx_valid held high
    frame(8'h01, 3'd4, 2'd0, 1'b0, 1'b1);
    frame(8'h80, 3'd4, 2'd0, 1'b0, 1'b1);
    frame(8'hFF, 3'd4, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_clear", tx_done, 1'b0);

    // T5: async reset during data bit 4
    tx_data = 8'h00; baud_set = 3'd4; parity_sel = 2'd0; two_stop = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (55) @(negedge clk);
    chk("pre_rst_tx_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_ready", tx_ready, 1'b1);
    chk("rst_mid_done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("post_rst_done", tx_done, 1'b0);
      chk("post_rst_tx", tx, 1'b1);
    end
    frame(8'hC6, 3'd4, 2'd1, 1'b0, 1'b0);
    @(negedge clk);

    // Randomised frames
    for (int n = 0; n < 10; n++) begin
      frame(8'($urandom), 3'($urandom_range(3, 6)), 2'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // T6: 5 data bits, 921600 baud, mark parity
    bps5 = CLK5_FREQ / 921600;
    b5_data = 5'h1F; b5_baud = 3'd7; b5_par = 2'd3; b5_ts = 1'b0; b5_valid = 1'b1;
    chk("t6_ready", b5_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b5_valid = 1'b0;
    b5_data = 5'h00;
    for (int k = 0; k < 8 * bps5; k++) begin
      chk("t6_wave", b5_tx, (k < bps5) ? 1'b0 : 1'b1);
      chk("t6_done_in_frame", b5_done, 1'b0);
      @(negedge clk);
    end
    chk("t6_done", b5_done, 1'b1);
    chk("t6_ready_end", b5_ready, 1'b1);
    b5_data = 5'h0A; b5_par = 2'd0; b5_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b5_valid = 1'b0;
    for (int k = 0; k < 7 * bps5; k++) begin
      chk("t6b_wave", b5_tx, (k < bps5) ? 1'b0 : ((k >= 6 * bps5) ? 1'b1 : 1'((5'h0A >> (k / bps5 - 1)) & 5'h01)));
      @(negedge clk);
    end
    chk("t6b_done", b5_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
